// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MIPS memory stage: data word, opcodes, memory FSM states
// and the LL/SC link granule helper.
package mem_access_unit_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [5:0] {
    RTYPE = 6'b000000,
    J     = 6'b000010,
    BEQ   = 6'b000100,
    ADDIU = 6'b001001,
    LW    = 6'b100011,
    SW    = 6'b101011,
    LL    = 6'b110000,
    SC    = 6'b111000
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } memstate_t;

  localparam int unsigned LINK_LSB_DEFAULT = 2;

  // Address with the low lsb bits cleared: the reservation granule of a.
  function automatic word_t granule(input word_t a, input int unsigned lsb);
    return a & ~((word_t'(1) << lsb) - word_t'(1));
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Datapath <-> dcache handshake. The memory stage is the master; the cache is the slave.
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  dhit;
  word_t dmemload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );
endinterface

// File: rtl/mem_access_unit_ll_sc_link.sv
// LL/SC reservation register: set by LL completion, cleared by SC/SW completion or a
// matching snoop invalidate. Set takes priority over any clear in the same cycle.
module ll_sc_link
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned LINK_LSB = LINK_LSB_DEFAULT
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  set,
  input  word_t set_addr,
  input  logic  clr,
  input  logic  snoop_inv,
  input  word_t snoop_addr,
  input  word_t chk_addr,
  output logic  match
);

  logic  link_valid;
  word_t link_addr;
  logic  snoop_hit;

  assign snoop_hit = snoop_inv &
                     (granule(snoop_addr, LINK_LSB) == granule(link_addr, LINK_LSB));
  assign match     = link_valid &
                     (granule(chk_addr, LINK_LSB) == granule(link_addr, LINK_LSB));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (set) begin
      link_valid <= 1'b1;
      link_addr  <= set_addr;
    end else if (clr | snoop_hit) begin
      link_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage of the 5-stage MIPS pipe: issues dcache requests, holds them until dhit,
// buffers results across a pipeline freeze and resolves LL/SC against the link register.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned LINK_LSB = LINK_LSB_DEFAULT
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               dREN_i,
  input  logic               dWEN_i,
  input  opcode_t            opcode_i,
  input  word_t              addr_i,
  input  word_t              store_i,
  input  logic               freeze_i,
  input  logic               snoop_inv,
  input  word_t              snoop_addr,
  output logic               mem_stall,
  output word_t              memdata_o,
  mem_access_unit_if.master  dcif
);

  memstate_t state, state_nxt;
  word_t     buf_q, live_data;
  logic      memop, is_sc, is_ll, is_sw;
  logic      link_match, sc_fail, active, req, done_evt, fail_evt;

  assign memop    = dREN_i | dWEN_i;
  assign is_sc    = (opcode_i == SC);
  assign is_ll    = (opcode_i == LL);
  assign is_sw    = (opcode_i == SW);
  assign sc_fail  = is_sc & ~link_match;
  assign active   = (state != DONE);
  assign req      = memop & ~sc_fail & active;
  assign done_evt = req & dcif.dhit;
  assign fail_evt = memop & sc_fail & active;

  ll_sc_link #(.LINK_LSB(LINK_LSB)) u_link (
    .CLK        (CLK),
    .nRST       (nRST),
    .set        (done_evt & is_ll),
    .set_addr   (addr_i),
    .clr        (((done_evt | fail_evt) & is_sc) | (done_evt & is_sw & link_match)),
    .snoop_inv  (snoop_inv),
    .snoop_addr (snoop_addr),
    .chk_addr   (addr_i),
    .match      (link_match)
  );

  always_comb begin
    live_data = '0;
    if (dREN_i)                live_data = dcif.dmemload;
    else if (is_sc & ~sc_fail) live_data = word_t'(1);
  end

  // WAIT shares IDLE's exits so an SC whose link is snooped away mid-wait retires as a fail.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, WAIT: begin
        if (done_evt | fail_evt) state_nxt = freeze_i ? DONE : IDLE;
        else if (req)            state_nxt = WAIT;
        else                     state_nxt = IDLE;
      end
      DONE:    if (!freeze_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      buf_q <= '0;
    end else begin
      state <= state_nxt;
      if (done_evt | fail_evt) buf_q <= live_data;
    end
  end

  // Outputs are qualified by nRST so an access in flight drops the moment reset asserts.
  assign dcif.dmemREN   = nRST & dREN_i & active;
  assign dcif.dmemWEN   = nRST & dWEN_i & ~sc_fail & active;
  assign dcif.dmemaddr  = nRST ? addr_i  : '0;
  assign dcif.dmemstore = nRST ? store_i : '0;
  assign mem_stall      = nRST & req & ~dcif.dhit;
  assign memdata_o      = (!nRST || !memop) ? '0 : (state == DONE) ? buf_q : live_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table, directed LL/SC/freeze/reset
// sequences, and a randomized run against a transaction-level reference model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int unsigned LSB = 2;

  logic    CLK = 1'b0;
  logic    nRST;
  logic    dREN_i, dWEN_i, freeze_i, snoop_inv, mem_stall;
  opcode_t opcode_i;
  word_t   addr_i, store_i, snoop_addr, memdata_o;

  int checks = 0;
  int errors = 0;

  mem_access_unit_if dcif();

  mem_access_unit #(.LINK_LSB(LSB)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .dREN_i     (dREN_i),
    .dWEN_i     (dWEN_i),
    .opcode_i   (opcode_i),
    .addr_i     (addr_i),
    .store_i    (store_i),
    .freeze_i   (freeze_i),
    .snoop_inv  (snoop_inv),
    .snoop_addr (snoop_addr),
    .mem_stall  (mem_stall),
    .memdata_o  (memdata_o),
    .dcif       (dcif)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drv(input logic ren, input logic wen, input opcode_t op, input word_t a,
                     input word_t s, input logic hit, input word_t ld, input logic frz);
    dREN_i = ren; dWEN_i = wen; opcode_i = op; addr_i = a; store_i = s;
    dcif.dhit = hit; dcif.dmemload = ld; freeze_i = frz;
    snoop_inv = 1'b0; snoop_addr = '0;
  endtask

  task automatic nop();
    drv(1'b0, 1'b0, RTYPE, '0, '0, 1'b0, '0, 1'b0);
  endtask

  // Check the four key outputs two time units after inputs settle.
  task automatic expect4(input string tag, input logic ren, input logic wen,
                         input logic stall, input word_t data);
    #2;
    chk({tag, ".ren"},   word_t'(dcif.dmemREN), word_t'(ren));
    chk({tag, ".wen"},   word_t'(dcif.dmemWEN), word_t'(wen));
    chk({tag, ".stall"}, word_t'(mem_stall),    word_t'(stall));
    chk({tag, ".data"},  memdata_o,             data);
  endtask

  task automatic do_reset();
    nop();
    nRST = 1'b0;
    tick(); tick();
    nRST = 1'b1;
    tick();
  endtask

  typedef struct {
    string   name;
    logic    ren, wen, hit;
    opcode_t op;
    word_t   addr, store, load;
    logic    e_ren, e_wen, e_stall;
    word_t   e_data;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: link reservation and "op already retired while frozen".
  logic  m_lv, m_done;
  word_t m_la, m_held;

  function automatic logic same_gran(input word_t a, input word_t b);
    return (a >> LSB) == (b >> LSB);
  endfunction

  initial begin
    // ---------------- reset state ----------------
    drv(1'b1, 1'b0, LW, 32'h100, 32'h55, 1'b1, 32'h1234, 1'b0);
    nRST = 1'b0;
    #3;
    expect4("reset", 1'b0, 1'b0, 1'b0, '0);
    chk("reset.addr", dcif.dmemaddr, '0);
    do_reset();

    // ---------------- vector table (fresh link) ----------------
    vecs = '{
      '{"nop",      0,0,0, RTYPE, 32'h0,  32'h0,  32'h0,        0,0,0, 32'h0},
      '{"lw_hit",   1,0,1, LW,    32'h10, 32'h0,  32'h11112222, 1,0,0, 32'h11112222},
      '{"lw_miss",  1,0,0, LW,    32'h14, 32'h0,  32'hAAAA5555, 1,0,1, 32'hAAAA5555},
      '{"lw_fill",  1,0,1, LW,    32'h14, 32'h0,  32'hAAAA5555, 1,0,0, 32'hAAAA5555},
      '{"sw_hit",   0,1,1, SW,    32'h20, 32'h55, 32'h0,        0,1,0, 32'h0},
      '{"sc_nolnk", 0,1,1, SC,    32'h30, 32'h9,  32'h0,        0,0,0, 32'h0},
      '{"sc_nl_nh", 0,1,0, SC,    32'h30, 32'h9,  32'h0,        0,0,0, 32'h0},
      '{"ll_hit",   1,0,1, LL,    32'h40, 32'h0,  32'h77,       1,0,0, 32'h77},
      '{"sc_wait",  0,1,0, SC,    32'h42, 32'h8,  32'h0,        0,1,1, 32'h1},
      '{"sc_ok",    0,1,1, SC,    32'h42, 32'h8,  32'h0,        0,1,0, 32'h1},
      '{"sc_again", 0,1,1, SC,    32'h40, 32'h8,  32'h0,        0,0,0, 32'h0}
    };
    foreach (vecs[i]) begin
      drv(vecs[i].ren, vecs[i].wen, vecs[i].op, vecs[i].addr, vecs[i].store,
          vecs[i].hit, vecs[i].load, 1'b0);
      expect4(vecs[i].name, vecs[i].e_ren, vecs[i].e_wen, vecs[i].e_stall, vecs[i].e_data);
      chk({vecs[i].name, ".addr"},  dcif.dmemaddr,  vecs[i].addr);
      chk({vecs[i].name, ".store"}, dcif.dmemstore, vecs[i].store);
      tick();
    end
    nop(); tick();

    // ---------------- LW with 3 miss cycles ----------------
    for (int c = 0; c < 3; c++) begin
      drv(1'b1, 1'b0, LW, 32'h100, '0, 1'b0, 32'h0, 1'b0);
      expect4("lw3.miss", 1'b1, 1'b0, 1'b1, 32'h0);
      tick();
    end
    drv(1'b1, 1'b0, LW, 32'h100, '0, 1'b1, 32'hDEADBEEF, 1'b0);
    expect4("lw3.hit", 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
    tick();

    // ---------------- SW same-cycle hit, then idle ----------------
    drv(1'b0, 1'b1, SW, 32'h200, 32'h1234, 1'b1, '0, 1'b0);
    expect4("sw.hit", 1'b0, 1'b1, 1'b0, 32'h0);
    chk("sw.store", dcif.dmemstore, 32'h1234);
    tick();
    nop();
    expect4("sw.after", 1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    // ---------------- LW hit under freeze: one read, buffered data ----------------
    drv(1'b1, 1'b0, LW, 32'h180, '0, 1'b1, 32'hCAFE0001, 1'b1);
    expect4("frz.hit", 1'b1, 1'b0, 1'b0, 32'hCAFE0001);
    tick();
    for (int c = 0; c < 4; c++) begin
      drv(1'b1, 1'b0, LW, 32'h180, '0, 1'b0, 32'h0BADF00D, 1'b1);
      expect4("frz.hold", 1'b0, 1'b0, 1'b0, 32'hCAFE0001);
      tick();
    end
    drv(1'b1, 1'b0, LW, 32'h180, '0, 1'b0, 32'h0BADF00D, 1'b0);
    expect4("frz.release", 1'b0, 1'b0, 1'b0, 32'hCAFE0001);
    tick();
    nop(); tick();

    // ---------------- LL/SC pairs and snoops ----------------
    drv(1'b1, 1'b0, LL, 32'h300, '0, 1'b1, 32'h5, 1'b0); tick();
    drv(1'b0, 1'b1, SC, 32'h300, 32'h99, 1'b1, '0, 1'b0);
    expect4("llsc.sc", 1'b0, 1'b1, 1'b0, 32'h1);
    tick();
    drv(1'b0, 1'b1, SC, 32'h300, 32'h99, 1'b1, '0, 1'b0);
    expect4("llsc.sc2", 1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    drv(1'b1, 1'b0, LL, 32'h300, '0, 1'b1, 32'h5, 1'b0); tick();
    nop(); snoop_inv = 1'b1; snoop_addr = 32'h304; tick();
    drv(1'b0, 1'b1, SC, 32'h300, 32'h1, 1'b1, '0, 1'b0);
    expect4("snp_other.sc", 1'b0, 1'b1, 1'b0, 32'h1);
    tick();

    drv(1'b1, 1'b0, LL, 32'h300, '0, 1'b1, 32'h5, 1'b0); tick();
    nop(); snoop_inv = 1'b1; snoop_addr = 32'h300; tick();
    drv(1'b0, 1'b1, SC, 32'h300, 32'h1, 1'b1, '0, 1'b0);
    expect4("snp_same.sc", 1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    drv(1'b1, 1'b0, LL, 32'h300, '0, 1'b1, 32'h5, 1'b0); tick();
    drv(1'b0, 1'b1, SC, 32'h300, 32'h1, 1'b1, '0, 1'b0);
    snoop_inv = 1'b1; snoop_addr = 32'h300;
    expect4("snp_sim.sc", 1'b0, 1'b1, 1'b0, 32'h1);
    tick();
    nop(); tick();

    // ---------------- reset while waiting ----------------
    drv(1'b1, 1'b0, LL, 32'h300, '0, 1'b1, 32'h5, 1'b0); tick();
    drv(1'b1, 1'b0, LW, 32'h100, '0, 1'b0, 32'h0, 1'b0); tick();
    #1 nRST = 1'b0;
    #1;
    chk("rst.ren",   word_t'(dcif.dmemREN), '0);
    chk("rst.stall", word_t'(mem_stall), '0);
    tick();
    nRST = 1'b1;
    expect4("rst.resume", 1'b1, 1'b0, 1'b1, 32'h0);
    tick();
    drv(1'b1, 1'b0, LW, 32'h100, '0, 1'b1, 32'h600D, 1'b0);
    expect4("rst.fill", 1'b1, 1'b0, 1'b0, 32'h600D);
    tick();
    drv(1'b0, 1'b1, SC, 32'h300, 32'h1, 1'b1, '0, 1'b0);
    expect4("rst.sc", 1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    // ---------------- randomized run vs reference model ----------------
    do_reset();
    m_lv = 1'b0; m_la = '0; m_done = 1'b0; m_held = '0;
    begin
      word_t   pool[4] = '{32'h300, 32'h302, 32'h304, 32'h500};
      logic    adv = 1'b1;
      logic    r_ren, r_wen;
      opcode_t r_op = RTYPE;
      word_t   r_addr = '0, r_store = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        logic  memop, is_sc, linked, fail, e_ren, e_wen, e_stall, retire;
        word_t e_data, result;
        if (adv) begin
          case ($urandom_range(0, 4))
            0: r_op = RTYPE;
            1: r_op = LW;
            2: r_op = SW;
            3: r_op = LL;
            default: r_op = SC;
          endcase
          r_addr  = pool[$urandom_range(0, 3)];
          r_store = $urandom;
        end
        r_ren = (r_op == LW) || (r_op == LL);
        r_wen = (r_op == SW) || (r_op == SC);
        drv(r_ren, r_wen, r_op, r_addr, r_store, ($urandom_range(0, 2) == 0), $urandom,
            ($urandom_range(0, 3) == 0));
        if ($urandom_range(0, 5) == 0) begin
          snoop_inv  = 1'b1;
          snoop_addr = pool[$urandom_range(0, 3)];
        end

        memop  = r_ren | r_wen;
        is_sc  = (r_op == SC);
        linked = m_lv && same_gran(m_la, r_addr);
        fail   = is_sc && !linked;
        result = fail ? 32'h0 : r_ren ? dcif.dmemload : is_sc ? 32'h1 : 32'h0;
        e_ren = 0; e_wen = 0; e_stall = 0; e_data = '0;
        if (memop) begin
          if (m_done)     e_data = m_held;
          else if (!fail) begin
            e_ren = r_ren; e_wen = r_wen; e_stall = !dcif.dhit; e_data = result;
          end
        end
        expect4("rand", e_ren, e_wen, e_stall, e_data);

        retire = memop && !m_done && (fail || dcif.dhit);
        adv = !e_stall && !freeze_i;
        if (m_done && !freeze_i) m_done = 1'b0;
        else if (retire && freeze_i) begin
          m_done = 1'b1;
          m_held = result;
        end
        if (snoop_inv && same_gran(snoop_addr, m_la)) m_lv = 1'b0;
        if (retire && is_sc) m_lv = 1'b0;
        if (retire && r_op == SW && linked) m_lv = 1'b0;
        if (retire && r_op == LL) begin
          m_lv = 1'b1;
          m_la = r_addr;
        end
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
